control_multi: RTL and testbench

Moore-style FSM that drives the multicycle RV32I datapath. It consumes the latched instruction word and produces every mux select and write/read strobe the datapath needs, one state per cycle. It sits directly upstream of the datapath and replaces no other block. The datapath's CSR/exception inputs are driven elsewhere; this block only flags illegal opcodes.

---
 rtl/control_multi.sv | 389 ++++++++++++++++++++++++++++++++++++++
 tb/tb_control_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_multi.sv
// control_multi -- Moore control FSM for the multicycle RV32I datapath.
//
// Walks one state per cycle through fetch, decode, execute, memory and
// write-back. Every mux select and strobe the datapath needs comes from this
// block. Outputs decode the state register combinationally. iInstr is used
// only in the states that need instruction fields. The datapath samples these
// outputs on iCLK, so short glitches are harmless.
//
// Ports:
//   iCLK, iRST        clock; synchronous active-high reset
//   iInstr[31:0]      latched IR contents
//   oEscreveIR        IR load strobe
//   oEscrevePC        unconditional PC write
//   oEscrevePCCond    PC write when the branch comparison is true
//   oEscrevePCBack    PCBack <= PC
//   oOrigAULA[1:0]    ALU A: 00=A, 01=PC, 10=PCBack, 11=zero
//   oOrigBULA[1:0]    ALU B: 00=B, 01=4, 10=immediate
//   oMem2Reg[1:0]     reg write data: 00=ALUOut, 01=PC, 10=MDR, 11=FP result
//   oOrigPC[1:0]      PC source: 00=ALU, 01=ALUOut, 10=ALU with bit0 cleared
//   oIouD             memory address: 0=PC, 1=ALUOut
//   oRegWrite, oMemWrite, oMemRead   strobes
//   oALUControl[4:0]  ALU operation code
//   oIllegal          one-cycle pulse in DECODE on an unknown opcode
//   oState[3:0]       current state, for monitoring
//
// Optional feature macro CONTROL_MULTI_FP_EN adds single-precision FP support.
// It adds the outputs oFRegWrite, oFPALUControl[4:0], oOrigAFPALU,
// oFPALUStart, oFWriteData and oWrite2Mem, and the input iFPALUReady.
// Without the macro, the FP opcodes are reported as illegal.

module control_multi (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iInstr,
    output logic        oEscreveIR,
    output logic        oEscrevePC,
    output logic        oEscrevePCCond,
    output logic        oEscrevePCBack,
    output logic [1:0]  oOrigAULA,
    output logic [1:0]  oOrigBULA,
    output logic [1:0]  oMem2Reg,
    output logic [1:0]  oOrigPC,
    output logic        oIouD,
    output logic        oRegWrite,
    output logic        oMemWrite,
    output logic        oMemRead,
    output logic [4:0]  oALUControl,
    output logic        oIllegal,
`ifdef CONTROL_MULTI_FP_EN
    output logic        oFRegWrite,
    output logic [4:0]  oFPALUControl,
    output logic        oOrigAFPALU,
    output logic        oFPALUStart,
    output logic        oFWriteData,
    output logic        oWrite2Mem,
    input  logic        iFPALUReady,
`endif
    output logic [3:0]  oState
);

    // ALU operation codes. The values must match the shared datapath ALU.
    localparam logic [4:0] OPADD    = 5'd0;
    localparam logic [4:0] OPSUB    = 5'd1;
    localparam logic [4:0] OPSLL    = 5'd2;
    localparam logic [4:0] OPSLT    = 5'd3;
    localparam logic [4:0] OPSLTU   = 5'd4;
    localparam logic [4:0] OPXOR    = 5'd5;
    localparam logic [4:0] OPSRL    = 5'd6;
    localparam logic [4:0] OPSRA    = 5'd7;
    localparam logic [4:0] OPOR     = 5'd8;
    localparam logic [4:0] OPAND    = 5'd9;
    localparam logic [4:0] OPMUL    = 5'd10;
    localparam logic [4:0] OPMULH   = 5'd11;
    localparam logic [4:0] OPMULHSU = 5'd12;
    localparam logic [4:0] OPMULHU  = 5'd13;
    localparam logic [4:0] OPDIV    = 5'd14;
    localparam logic [4:0] OPDIVU   = 5'd15;
    localparam logic [4:0] OPREM    = 5'd16;
    localparam logic [4:0] OPREMU   = 5'd17;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
`ifdef CONTROL_MULTI_FP_EN
    localparam logic [6:0] OPC_FP     = 7'b1010011;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_ADDR    = 4'd4,
        S_MEM_LD  = 4'd5,
        S_LD_WB   = 4'd6,
        S_MEM_ST  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_JALR    = 4'd11,
        S_LUI     = 4'd12,
        S_AUIPC   = 4'd13,
        S_FP_EXEC = 4'd14,
        S_FP_WAIT = 4'd15
    } state_t;

    state_t     r_state;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_load;
    logic [4:0] w_alu_r;
    logic [4:0] w_alu_i;

    assign w_opcode = iInstr[6:0];
    assign w_funct3 = iInstr[14:12];
    assign w_funct7 = iInstr[31:25];
    assign oState   = r_state;

`ifdef CONTROL_MULTI_FP_EN
    assign w_is_load = (w_opcode == OPC_LOAD) || (w_opcode == OPC_FLW);

    // FP ops whose result goes to the integer register file:
    // compare, fcvt.w[u].s, and fmv.x.w/fclass.
    logic w_fp_int_dst;
    assign w_fp_int_dst = (w_funct7[6:2] == 5'b10100) ||
                          (w_funct7[6:2] == 5'b11000) ||
                          (w_funct7[6:2] == 5'b11100);

    // FP ops whose A operand comes from the integer file: fcvt.s.w[u] and fmv.w.x.
    logic w_fp_int_src;
    assign w_fp_int_src = (w_funct7[6:2] == 5'b11010) ||
                          (w_funct7[6:2] == 5'b11110);
`else
    assign w_is_load = (w_opcode == OPC_LOAD);
`endif

    // R-type op select. funct7 = 0000001 picks the M extension.
    always_comb begin
        w_alu_r = OPADD;
        if (w_funct7 == 7'b0000001) begin
            case (w_funct3)
                3'd0:    w_alu_r = OPMUL;
                3'd1:    w_alu_r = OPMULH;
                3'd2:    w_alu_r = OPMULHSU;
                3'd3:    w_alu_r = OPMULHU;
                3'd4:    w_alu_r = OPDIV;
                3'd5:    w_alu_r = OPDIVU;
                3'd6:    w_alu_r = OPREM;
                default: w_alu_r = OPREMU;
            endcase
        end else begin
            case (w_funct3)
                3'd0:    w_alu_r = w_funct7[5] ? OPSUB : OPADD;
                3'd1:    w_alu_r = OPSLL;
                3'd2:    w_alu_r = OPSLT;
                3'd3:    w_alu_r = OPSLTU;
                3'd4:    w_alu_r = OPXOR;
                3'd5:    w_alu_r = w_funct7[5] ? OPSRA : OPSRL;
                3'd6:    w_alu_r = OPOR;
                default: w_alu_r = OPAND;
            endcase
        end
    end

    // I-type op select. imm[10] is bit 30 and distinguishes SRAI only.
    // ADDI never becomes a subtract.
    always_comb begin
        case (w_funct3)
            3'd0:    w_alu_i = OPADD;
            3'd1:    w_alu_i = OPSLL;
            3'd2:    w_alu_i = OPSLT;
            3'd3:    w_alu_i = OPSLTU;
            3'd4:    w_alu_i = OPXOR;
            3'd5:    w_alu_i = w_funct7[5] ? OPSRA : OPSRL;
            3'd6:    w_alu_i = OPOR;
            default: w_alu_i = OPAND;
        endcase
    end

    // State register and transitions
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_opcode)
                        OPC_R:      r_state <= S_EXEC_R;
                        OPC_I:      r_state <= S_EXEC_I;
                        OPC_LOAD,
                        OPC_STORE:  r_state <= S_ADDR;
                        OPC_BRANCH: r_state <= S_BRANCH;
                        OPC_JAL:    r_state <= S_JAL;
                        OPC_JALR:   r_state <= S_JALR;
                        OPC_LUI:    r_state <= S_LUI;
                        OPC_AUIPC:  r_state <= S_AUIPC;
`ifdef CONTROL_MULTI_FP_EN
                        OPC_FP:     r_state <= S_FP_EXEC;
                        OPC_FLW,
                        OPC_FSW:    r_state <= S_ADDR;
`endif
                        default:    r_state <= S_FETCH;
                    endcase
                end
                S_ADDR:   r_state <= w_is_load ? S_MEM_LD : S_MEM_ST;
                S_MEM_LD: r_state <= S_LD_WB;
                S_EXEC_R,
                S_EXEC_I,
                S_LUI,
                S_AUIPC:  r_state <= S_ALU_WB;
`ifdef CONTROL_MULTI_FP_EN
                S_FP_EXEC: r_state <= S_FP_WAIT;
                S_FP_WAIT: r_state <= iFPALUReady ? S_ALU_WB : S_FP_WAIT;
`endif
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Output decode
    always_comb begin
        oEscreveIR     = 1'b0;
        oEscrevePC     = 1'b0;
        oEscrevePCCond = 1'b0;
        oEscrevePCBack = 1'b0;
        oOrigAULA      = 2'b00;
        oOrigBULA      = 2'b00;
        oMem2Reg       = 2'b00;
        oOrigPC        = 2'b00;
        oIouD          = 1'b0;
        oRegWrite      = 1'b0;
        oMemWrite      = 1'b0;
        oMemRead       = 1'b0;
        oALUControl    = OPADD;
        oIllegal       = 1'b0;
`ifdef CONTROL_MULTI_FP_EN
        oFRegWrite     = 1'b0;
        oFPALUControl  = 5'd0;
        oOrigAFPALU    = 1'b0;
        oFPALUStart    = 1'b0;
        oFWriteData    = 1'b0;
        oWrite2Mem     = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                oMemRead       = 1'b1;
                oEscreveIR     = 1'b1;
                oEscrevePCBack = 1'b1;
                oOrigAULA      = 2'b01;
                oOrigBULA      = 2'b01;
                oEscrevePC     = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch/jal target from PCBack + imm
                oOrigAULA = 2'b10;
                oOrigBULA = 2'b10;
                case (w_opcode)
                    OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                    OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: oIllegal = 1'b0;
`ifdef CONTROL_MULTI_FP_EN
                    OPC_FP, OPC_FLW, OPC_FSW:              oIllegal = 1'b0;
`endif
                    default:                               oIllegal = 1'b1;
                endcase
            end
            S_EXEC_R: oALUControl = w_alu_r;
            S_EXEC_I: begin
                oOrigBULA   = 2'b10;
                oALUControl = w_alu_i;
            end
            S_ADDR:   oOrigBULA = 2'b10;
            S_MEM_LD: begin
                oIouD    = 1'b1;
                oMemRead = 1'b1;
            end
            S_LD_WB: begin
`ifdef CONTROL_MULTI_FP_EN
                if (w_opcode == OPC_FLW) begin
                    oFRegWrite = 1'b1;
                end else begin
                    oMem2Reg  = 2'b10;
                    oRegWrite = 1'b1;
                end
`else
                oMem2Reg  = 2'b10;
                oRegWrite = 1'b1;
`endif
            end
            S_MEM_ST: begin
                oIouD     = 1'b1;
                oMemWrite = 1'b1;
`ifdef CONTROL_MULTI_FP_EN
                oWrite2Mem = (w_opcode == OPC_FSW);
`endif
            end
            S_ALU_WB: begin
`ifdef CONTROL_MULTI_FP_EN
                if (w_opcode == OPC_FP) begin
                    if (w_fp_int_dst) begin
                        oMem2Reg  = 2'b11;
                        oRegWrite = 1'b1;
                    end else begin
                        oFWriteData = 1'b1;
                        oFRegWrite  = 1'b1;
                    end
                end else begin
                    oRegWrite = 1'b1;
                end
`else
                oRegWrite = 1'b1;
`endif
            end
            S_BRANCH: begin
                oEscrevePCCond = 1'b1;
                oOrigPC        = 2'b01;
            end
            S_JAL: begin
                oMem2Reg   = 2'b01;
                oRegWrite  = 1'b1;
                oOrigPC    = 2'b01;
                oEscrevePC = 1'b1;
            end
            S_JALR: begin
                oOrigBULA  = 2'b10;
                oOrigPC    = 2'b10;
                oEscrevePC = 1'b1;
                oMem2Reg   = 2'b01;
                oRegWrite  = 1'b1;
            end
            S_LUI: begin
                oOrigAULA = 2'b11;
                oOrigBULA = 2'b10;
            end
            S_AUIPC: begin
                oOrigAULA = 2'b10;
                oOrigBULA = 2'b10;
            end
`ifdef CONTROL_MULTI_FP_EN
            S_FP_EXEC: begin
                oFPALUStart   = 1'b1;
                oFPALUControl = w_funct7[6:2];
                oOrigAFPALU   = w_fp_int_src;
            end
            S_FP_WAIT: begin
                oFPALUControl = w_funct7[6:2];
                oOrigAFPALU   = w_fp_int_src;
            end
`endif
            default: ;
        endcase

        // Reset aborts the instruction in flight. Nothing may be written this cycle.
        if (iRST) begin
            oEscreveIR     = 1'b0;
            oEscrevePC     = 1'b0;
            oEscrevePCCond = 1'b0;
            oEscrevePCBack = 1'b0;
            oOrigAULA      = 2'b00;
            oOrigBULA      = 2'b00;
            oMem2Reg       = 2'b00;
            oOrigPC        = 2'b00;
            oIouD          = 1'b0;
            oRegWrite      = 1'b0;
            oMemWrite      = 1'b0;
            oMemRead       = 1'b0;
            oALUControl    = OPADD;
            oIllegal       = 1'b0;
`ifdef CONTROL_MULTI_FP_EN
            oFRegWrite     = 1'b0;
            oFPALUControl  = 5'd0;
            oOrigAFPALU    = 1'b0;
            oFPALUStart    = 1'b0;
            oFWriteData    = 1'b0;
            oWrite2Mem     = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_control_multi.sv
module tb_control_multi;

    localparam logic [4:0] OPADD = 5'd0, OPSUB = 5'd1, OPSLL = 5'd2, OPSLT = 5'd3,
                           OPSLTU = 5'd4, OPXOR = 5'd5, OPSRL = 5'd6, OPSRA = 5'd7,
                           OPOR = 5'd8, OPAND = 5'd9, OPMUL = 5'd10;

    typedef struct packed {
        logic [3:0] st;
        logic       ir, pc, pccond, pcback;
        logic [1:0] oa, ob, m2r, opc;
        logic       iord, rw, mw, mr;
        logic [4:0] alu;
        logic       ill;
        logic       frw;
        logic [4:0] fpop;
        logic       ofa, fst, fwd, w2m;
    } rec_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [31:0] iInstr = 32'h0;
    logic        oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack;
    logic [1:0]  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC;
    logic        oIouD, oRegWrite, oMemWrite, oMemRead, oIllegal;
    logic [4:0]  oALUControl;
    logic [3:0]  oState;
    logic        fRW, fOA, fST, fWD, fW2M;
    logic [4:0]  fOP;
`ifdef CONTROL_MULTI_FP_EN
    logic        iFPALUReady = 1'b1;
`endif

    control_multi dut (
        .iCLK(iCLK), .iRST(iRST), .iInstr(iInstr),
        .oEscreveIR(oEscreveIR), .oEscrevePC(oEscrevePC),
        .oEscrevePCCond(oEscrevePCCond), .oEscrevePCBack(oEscrevePCBack),
        .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA), .oMem2Reg(oMem2Reg),
        .oOrigPC(oOrigPC), .oIouD(oIouD), .oRegWrite(oRegWrite),
        .oMemWrite(oMemWrite), .oMemRead(oMemRead), .oALUControl(oALUControl),
        .oIllegal(oIllegal),
`ifdef CONTROL_MULTI_FP_EN
        .oFRegWrite(fRW), .oFPALUControl(fOP), .oOrigAFPALU(fOA),
        .oFPALUStart(fST), .oFWriteData(fWD), .oWrite2Mem(fW2M),
        .iFPALUReady(iFPALUReady),
`endif
        .oState(oState)
    );

`ifndef CONTROL_MULTI_FP_EN
    assign {fRW, fOA, fST, fWD, fW2M} = '0;
    assign fOP = '0;
`endif

    always #5 iCLK = ~iCLK;

    rec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model
    function automatic bit legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
`ifdef CONTROL_MULTI_FP_EN
            7'b1010011, 7'b0000111, 7'b0100111: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [31:0] ins, input bit isR);
        logic [4:0] base [8];
        logic [2:0] f3;
        base = '{OPADD, OPSLL, OPSLT, OPSLTU, OPXOR, OPSRL, OPOR, OPAND};
        f3 = ins[14:12];
        if (isR && ins[31:25] == 7'd1) return OPMUL + {2'b00, f3};
        if (isR && f3 == 3'd0 && ins[30]) return OPSUB;
        if (f3 == 3'd5 && ins[30]) return OPSRA;
        return base[f3];
    endfunction

    function automatic rec_t exp_out(input int st, input logic [31:0] ins, input bit rst);
        rec_t r;
        logic [6:0] op;
        logic [4:0] fk;
        op = ins[6:0];
        fk = ins[31:27];
        r = '0;
        r.st = 4'(st);
        if (rst) return r;
        case (st)
            0:  begin r.mr = 1; r.ir = 1; r.pcback = 1; r.oa = 1; r.ob = 1; r.pc = 1; end
            1:  begin r.oa = 2; r.ob = 2; r.ill = !legal(op); end
            2:  r.alu = alu_of(ins, 1'b1);
            3:  begin r.ob = 2; r.alu = alu_of(ins, 1'b0); end
            4:  r.ob = 2;
            5:  begin r.iord = 1; r.mr = 1; end
            6:  if (op == 7'b0000111) r.frw = 1; else begin r.m2r = 2; r.rw = 1; end
            7:  begin r.iord = 1; r.mw = 1; r.w2m = (op == 7'b0100111); end
            8:  if (op == 7'b1010011) begin
                    if (fk == 5'b10100 || fk == 5'b11000 || fk == 5'b11100) begin
                        r.m2r = 3; r.rw = 1;
                    end else begin
                        r.fwd = 1; r.frw = 1;
                    end
                end else r.rw = 1;
            9:  begin r.pccond = 1; r.opc = 1; end
            10: begin r.m2r = 1; r.rw = 1; r.opc = 1; r.pc = 1; end
            11: begin r.ob = 2; r.opc = 2; r.pc = 1; r.m2r = 1; r.rw = 1; end
            12: begin r.oa = 3; r.ob = 2; end
            13: begin r.oa = 2; r.ob = 2; end
            14: begin r.fst = 1; r.fpop = fk; r.ofa = (fk == 5'b11010 || fk == 5'b11110); end
            15: begin r.fpop = fk; r.ofa = (fk == 5'b11010 || fk == 5'b11110); end
            default: ;
        endcase
        return r;
    endfunction

    // State walk per instruction class (non-FP), derived from the cycle counts
    task automatic path_of(input logic [31:0] ins, output int p[$]);
        case (ins[6:0])
            7'b0110011: p = '{0, 1, 2, 8};
            7'b0010011: p = '{0, 1, 3, 8};
            7'b0000011: p = '{0, 1, 4, 5, 6};
            7'b0100011: p = '{0, 1, 4, 7};
            7'b1100011: p = '{0, 1, 9};
            7'b1101111: p = '{0, 1, 10};
            7'b1100111: p = '{0, 1, 11};
            7'b0110111: p = '{0, 1, 12, 8};
            7'b0010111: p = '{0, 1, 13, 8};
            default:    p = '{0, 1};
        endcase
    endtask

    // Called at posedge+1 with the DUT in FETCH. abort_at >= 0 raises reset
    // during that cycle of the instruction.
    task automatic issue(input logic [31:0] ins, input int abort_at);
        int p[$];
        int n;
        path_of(ins, p);
        n = (abort_at >= 0 && abort_at < p.size()) ? abort_at : p.size();
        iInstr = ins;
        for (int k = 0; k < n; k++) exp_q.push_back(exp_out(p[k], ins, 1'b0));
        if (n < p.size()) exp_q.push_back(exp_out(p[n], ins, 1'b1));
        repeat (n) @(posedge iCLK);
        #1;
        if (n < p.size()) begin
            iRST = 1'b1;
            @(posedge iCLK);
            #1;
            iRST = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int c;
        r = $urandom;
        c = $urandom_range(0, 9);
        case (c)
            0: begin
                r[6:0] = 7'b0110011;
                case ($urandom_range(0, 2))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    default: r[31:25] = 7'h01;
                endcase
            end
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0000011;
            3: r[6:0] = 7'b0100011;
            4: r[6:0] = 7'b1100011;
            5: r[6:0] = 7'b1101111;
            6: r[6:0] = 7'b1100111;
            7: r[6:0] = 7'b0110111;
            8: r[6:0] = 7'b0010111;
            default: begin
                r[6:0] = 7'($urandom);
                while (legal(r[6:0])) r[6:0] = 7'($urandom);
            end
        endcase
        return r;
    endfunction

    // Monitor: one output vector per cycle while a response is expected
    always @(negedge iCLK) begin
        if (exp_q.size() > 0) begin
            rec_t e, a;
            e = exp_q.pop_front();
            a.st = oState; a.ir = oEscreveIR; a.pc = oEscrevePC; a.pccond = oEscrevePCCond;
            a.pcback = oEscrevePCBack; a.oa = oOrigAULA; a.ob = oOrigBULA; a.m2r = oMem2Reg;
            a.opc = oOrigPC; a.iord = oIouD; a.rw = oRegWrite; a.mw = oMemWrite;
            a.mr = oMemRead; a.alu = oALUControl; a.ill = oIllegal; a.frw = fRW;
            a.fpop = fOP; a.ofa = fOA; a.fst = fST; a.fwd = fWD; a.w2m = fW2M;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL ctrl_vec t=%0t instr=%h state got %0d want %0d; outputs got %h want %h",
                         $time, iInstr, a.st, e.st, a, e);
            end
        end
    end

    initial begin
        repeat (3) @(posedge iCLK);
        #1;
        // Reset state: FETCH with every strobe held low
        exp_q.push_back(exp_out(0, 32'h0, 1'b1));
        @(posedge iCLK);
        #1;
        iRST = 1'b0;

        issue(32'h002081B3, -1);   // add x3,x1,x2
        issue(32'h0000A183, -1);   // lw x3,0(x1)
        issue(32'h00000463, -1);   // beq x0,x0,8
        issue(32'hFFFFFFFF, -1);   // illegal
        issue(32'h4020D193, -1);   // srai
        issue(32'h40000193, -1);   // addi with imm[10] set: still ADD
        issue(32'h0000A183, 3);    // lw, reset during MEM_LD
        issue(32'h002081B3, -1);

`ifdef CONTROL_MULTI_FP_EN
        // fadd.s, ready low for the first five FP_WAIT cycles -> six FP_WAIT cycles
        iInstr = 32'h00208053;
        iFPALUReady = 1'b0;
        exp_q.push_back(exp_out(0, iInstr, 1'b0));
        exp_q.push_back(exp_out(1, iInstr, 1'b0));
        exp_q.push_back(exp_out(14, iInstr, 1'b0));
        repeat (6) exp_q.push_back(exp_out(15, iInstr, 1'b0));
        exp_q.push_back(exp_out(8, iInstr, 1'b0));
        repeat (8) @(posedge iCLK);
        #1;
        iFPALUReady = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        // ready already high: FP_WAIT lasts one cycle
        exp_q.push_back(exp_out(0, iInstr, 1'b0));
        exp_q.push_back(exp_out(1, iInstr, 1'b0));
        exp_q.push_back(exp_out(14, iInstr, 1'b0));
        exp_q.push_back(exp_out(15, iInstr, 1'b0));
        exp_q.push_back(exp_out(8, iInstr, 1'b0));
        repeat (5) @(posedge iCLK);
        #1;
`endif

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) issue(rand_instr(), $urandom_range(0, 4));
            else issue(rand_instr(), -1);
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge iCLK);
        @(negedge iCLK);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never observed, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
